// File: rtl/tb_clk_div_gen.sv
// Multi-channel clock divider with post-reset ready sequencing.
// Optional free-running cycle counter enabled by defining TB_CLK_GEN_CYCLE_CNT_EN.

module tb_clk_div_gen_ch #(
  parameter int DIV_W = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             ready,
  input  logic             en,
  input  logic [DIV_W-1:0] div_val,
  input  logic             div_load,
  output logic             ch_clk,
  output logic             ch_tick
);
  logic [DIV_W-1:0] div_q, div_d;
  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic [DIV_W-1:0] deff, last;
  logic             active;

  always_comb begin
    active = ready & en;
    // A zero divisor behaves as divide-by-1
    deff   = (div_q == '0) ? DIV_W'(1) : div_q;
    last   = deff - DIV_W'(1);
    div_d  = div_q;
    cnt_d  = cnt_q + DIV_W'(1);
    if (div_load) begin
      div_d = div_val;
      cnt_d = '0;
    end else if (!active) begin
      cnt_d = '0;
    end else if (cnt_q >= last) begin
      // >= also recovers when the divisor shrinks below the running count
      cnt_d = '0;
    end
    ch_tick = active && (cnt_q == last);
    ch_clk  = active && (deff >= DIV_W'(2)) && (cnt_q < (deff >> 1));
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      div_q <= DIV_W'(2);
      cnt_q <= '0;
    end else begin
      div_q <= div_d;
      cnt_q <= cnt_d;
    end
  end
endmodule

module tb_clk_div_gen #(
  parameter int NUM_CH      = 4,
  parameter int DIV_W       = 8,
  parameter int READY_DELAY = 2
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic [NUM_CH-1:0]       ch_en,
  input  logic [NUM_CH*DIV_W-1:0] div_val,
  input  logic [NUM_CH-1:0]       div_load,
  output logic                    ready,
  output logic [NUM_CH-1:0]       ch_clk,
  output logic [NUM_CH-1:0]       ch_tick
`ifdef TB_CLK_GEN_CYCLE_CNT_EN
  ,
  output logic [31:0]             cycle_cnt
`endif
);
  localparam int RW = $clog2(READY_DELAY + 1);

  logic [RW-1:0] rdy_cnt_q, rdy_cnt_d;
  logic          ready_q, ready_d;

  always_comb begin
    rdy_cnt_d = (rdy_cnt_q == RW'(READY_DELAY)) ? rdy_cnt_q : rdy_cnt_q + RW'(1);
    ready_d   = ready_q | (rdy_cnt_d == RW'(READY_DELAY));
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rdy_cnt_q <= '0;
      ready_q   <= 1'b0;
    end else begin
      rdy_cnt_q <= rdy_cnt_d;
      ready_q   <= ready_d;
    end
  end

  assign ready = ready_q;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    tb_clk_div_gen_ch #(.DIV_W(DIV_W)) u_ch (
      .clk      (clk),
      .reset_n  (reset_n),
      .ready    (ready_q),
      .en       (ch_en[i]),
      .div_val  (div_val[i*DIV_W +: DIV_W]),
      .div_load (div_load[i]),
      .ch_clk   (ch_clk[i]),
      .ch_tick  (ch_tick[i])
    );
  end

`ifdef TB_CLK_GEN_CYCLE_CNT_EN
  logic [31:0] cycle_cnt_q, cycle_cnt_d;

  always_comb cycle_cnt_d = ready_q ? cycle_cnt_q + 32'd1 : 32'd0;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) cycle_cnt_q <= 32'd0;
    else          cycle_cnt_q <= cycle_cnt_d;
  end

  assign cycle_cnt = cycle_cnt_q;
`endif
endmodule
